// File: rtl/sliding_window_gen_pkg.sv
// Shared image-pipeline package, used by the window generator and the blur filter.
//   IMG_DATA_W : default pixel width
//   IMG_WIN_K  : default square window size
//   pixel_t    : one pixel
//   window_t   : K x K window, indexed [y][x] (y=0 oldest line, x=0 leftmost column)
//   cnt_w()    : width of a counter or address that covers 0..n-1 (at least 1 bit)
package sliding_window_gen_pkg;

  localparam int IMG_DATA_W = 8;
  localparam int IMG_WIN_K  = 5;

  typedef logic [IMG_DATA_W-1:0] pixel_t;
  typedef pixel_t [IMG_WIN_K-1:0][IMG_WIN_K-1:0] window_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sliding_window_gen_line_buf.sv
// One line of pixel storage, DEPTH x DATA_W, single address.
// The read is combinational, so it returns the old word at addr in the same
// cycle that a write to addr is presented; the write lands on the clock edge
// (read-before-write). The storage has no reset so it can map to RAM.
//   clk   : clock
//   we    : write enable
//   addr  : read/write address
//   wdata : data written on the edge when we is high
//   rdata : current (pre-write) contents at addr
module line_buf_ram
  import sliding_window_gen_pkg::*;
#(
  parameter int DEPTH  = 640,
  parameter int DATA_W = IMG_DATA_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [cnt_w(DEPTH)-1:0]  addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sliding_window_gen.sv
// Sliding K x K window generator over a raster pixel stream (valid-only
// windows: no border padding, no wrap across lines).
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   i_valid  : pixel accepted this cycle
//   i_sof    : start of frame, forces the accepted pixel to position (0,0)
//   i_pixel  : raster-order pixel
//   o_valid  : one-cycle pulse, window holds a complete in-frame window
//   window   : window[y][x], y=0 oldest line, x=0 leftmost column
//              (same layout as window_t when K/DATA_W are at their defaults)
//   o_eof    : with o_valid, marks the last window of the frame
module sliding_window_gen
  import sliding_window_gen_pkg::*;
#(
  parameter int K      = IMG_WIN_K,
  parameter int DATA_W = IMG_DATA_W,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_valid,
  input  logic                             i_sof,
  input  logic [DATA_W-1:0]                i_pixel,
  output logic                             o_valid,
  output logic [K-1:0][K-1:0][DATA_W-1:0]  window,
  output logic                             o_eof
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);

  logic [CW-1:0]     col_p0;
  logic [RW-1:0]     row_p0;
  logic [CW-1:0]     eff_col;
  logic [RW-1:0]     eff_row;
  logic              win_ok;
  logic              at_last;
  logic [DATA_W-1:0] lb_rd [K-1];
  logic [DATA_W-1:0] lb_wd [K-1];

  // i_sof only matters on an accepted pixel, and then it wins over the counters.
  assign eff_col = i_sof ? '0 : col_p0;
  assign eff_row = i_sof ? '0 : row_p0;

  // Gating on the in-frame position means stale line-buffer rows from an
  // earlier frame (or from before a reset) never reach a valid window.
  assign win_ok  = (eff_col >= CW'(K-1)) && (eff_row >= RW'(K-1));
  assign at_last = (eff_col == CW'(IMG_W-1)) && (eff_row == RW'(IMG_H-1));

  // Line buffers form a vertical shift chain at the current column:
  // each buffer takes the word the next-newer buffer held, the newest takes i_pixel.
  for (genvar k = 0; k < K-1; k++) begin : g_lb
    if (k == K-2) begin : g_top
      assign lb_wd[k] = i_pixel;
    end else begin : g_mid
      assign lb_wd[k] = lb_rd[k+1];
    end

    line_buf_ram #(
      .DEPTH  (IMG_W),
      .DATA_W (DATA_W)
    ) u_lb (
      .clk   (clk),
      .we    (i_valid),
      .addr  (eff_col),
      .wdata (lb_wd[k]),
      .rdata (lb_rd[k])
    );
  end

  // ---- p0: position counters (next accepted pixel) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_p0 <= '0;
      row_p0 <= '0;
    end else if (i_valid) begin
      if (eff_col == CW'(IMG_W-1)) begin
        col_p0 <= '0;
        row_p0 <= (eff_row == RW'(IMG_H-1)) ? '0 : eff_row + RW'(1);
      end else begin
        col_p0 <= eff_col + CW'(1);
        row_p0 <= eff_row;
      end
    end
  end

  // ---- p1: window register and its valid/eof flags ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_eof   <= 1'b0;
      window  <= '0;
    end else begin
      o_valid <= i_valid && win_ok;
      o_eof   <= i_valid && win_ok && at_last;
      if (i_valid) begin
        for (int y = 0; y < K; y++) begin
          for (int x = 0; x < K-1; x++) begin
            window[y][x] <= window[y][x+1];
          end
        end
        for (int y = 0; y < K-1; y++) begin
          window[y][K-1] <= lb_rd[y];
        end
        window[K-1][K-1] <= i_pixel;
      end
    end
  end

endmodule

// File: tb/tb_sliding_window_gen.sv
module tb_sliding_window_gen;

  localparam int K      = 3;
  localparam int DATA_W = 8;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 6;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NWIN   = (IMG_W - K + 1) * (IMG_H - K + 1);

  typedef logic [K-1:0][K-1:0][DATA_W-1:0] win_t;

  logic              clk;
  logic              rst_n;
  logic              i_valid;
  logic              i_sof;
  logic [DATA_W-1:0] i_pixel;
  logic              o_valid;
  win_t              window;
  logic              o_eof;

  int checks = 0;
  int errors = 0;

  // Reference model: the frame as a 2-D image indexed by absolute position.
  logic [DATA_W-1:0] img [IMG_H][IMG_W];
  int m_pos = 0;

  sliding_window_gen #(
    .K      (K),
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_sof   (i_sof),
    .i_pixel (i_pixel),
    .o_valid (o_valid),
    .window  (window),
    .o_eof   (o_eof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] pat(input int p);
    return DATA_W'((p / IMG_W) * 16 + (p % IMG_W));
  endfunction

  // Presents one cycle of input (called at posedge+1), returns what the model
  // expects to see on the outputs after the next edge, and leaves time at posedge+1.
  task automatic drive(input logic v, input logic sof, input logic [DATA_W-1:0] pix,
                       output logic ev, output logic ee, output win_t ew);
    int c, r;
    i_valid = v;
    i_sof   = sof;
    i_pixel = pix;
    ev = 1'b0;
    ee = 1'b0;
    ew = '0;
    if (v) begin
      if (sof) m_pos = 0;
      c = m_pos % IMG_W;
      r = m_pos / IMG_W;
      img[r][c] = pix;
      if (c >= K-1 && r >= K-1) begin
        ev = 1'b1;
        ee = (c == IMG_W-1) && (r == IMG_H-1);
        for (int y = 0; y < K; y++)
          for (int x = 0; x < K; x++)
            ew[y][x] = img[r-K+1+y][c-K+1+x];
      end
      m_pos = (m_pos + 1) % NPIX;
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (o_valid !== 1'b0 || o_eof !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got valid=%b eof=%b want 0 0", o_valid, o_eof);
    end
    checks++;
    if (window !== '0) begin
      errors++;
      $display("FAIL reset_window got %h want 0", window);
    end
  endtask

  // One pattern frame (pixel = row*16+col) with random idle cycles between pixels.
  task automatic test_stream(input int gap_pct, input bit use_sof, input string name);
    logic ev, ee;
    win_t ew;
    int nwin = 0;
    bit first = 1'b1;
    for (int p = 0; p < NPIX; p++) begin
      while ($urandom_range(99) < gap_pct) begin
        drive(1'b0, 1'b0, DATA_W'($urandom), ev, ee, ew);
        checks++;
        if (o_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s_idle_valid pos=%0d got %b want 0", name, p, o_valid);
        end
      end
      drive(1'b1, use_sof && (p == 0), pat(p), ev, ee, ew);
      checks++;
      if (o_valid !== ev) begin
        errors++;
        $display("FAIL %s_valid pos=%0d got %b want %b", name, p, o_valid, ev);
      end
      if (ev) begin
        nwin++;
        checks++;
        if (window !== ew || o_eof !== ee) begin
          errors++;
          $display("FAIL %s_window pos=%0d got %h eof=%b want %h eof=%b", name, p, window, o_eof, ew, ee);
        end
        if (first) begin
          first = 1'b0;
          checks++;
          if (window[0][0] !== 8'h00 || window[1][1] !== 8'h11 || window[2][2] !== 8'h22) begin
            errors++;
            $display("FAIL %s_first_win got %h %h %h want 00 11 22", name,
                     window[0][0], window[1][1], window[2][2]);
          end
        end
        if (p == NPIX-1) begin
          checks++;
          if (o_eof !== 1'b1 || window[2][2] !== 8'h57) begin
            errors++;
            $display("FAIL %s_eof got eof=%b px=%h want 1 57", name, o_eof, window[2][2]);
          end
        end
      end
    end
    checks++;
    if (nwin != NWIN) begin
      errors++;
      $display("FAIL %s_count got %0d want %0d", name, nwin, NWIN);
    end
  endtask

  task automatic test_line_boundary;
    logic ev, ee;
    win_t ew;
    for (int p = 0; p < NPIX; p++) begin
      drive(1'b1, p == 0, pat(p), ev, ee, ew);
      if (p == 3*IMG_W || p == 3*IMG_W + 1) begin
        checks++;
        if (o_valid !== 1'b0) begin
          errors++;
          $display("FAIL lb_early_valid pos=%0d got %b want 0", p, o_valid);
        end
      end
      if (p == 3*IMG_W + 2) begin
        checks++;
        if (o_valid !== 1'b1 || window[2][0] !== 8'h30 || window[2][1] !== 8'h31 ||
            window[2][2] !== 8'h32) begin
          errors++;
          $display("FAIL lb_row3 got valid=%b %h %h %h want 1 30 31 32", o_valid,
                   window[2][0], window[2][1], window[2][2]);
        end
      end
    end
  endtask

  // Random pixel values and random gaps, followed directly by a pattern frame.
  task automatic test_back_to_back;
    logic ev, ee;
    win_t ew;
    int nwin = 0;
    for (int p = 0; p < NPIX; p++) begin
      if ($urandom_range(99) < 30) begin
        drive(1'b0, 1'b0, DATA_W'($urandom), ev, ee, ew);
        checks++;
        if (o_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_idle_valid pos=%0d got %b want 0", p, o_valid);
        end
      end
      drive(1'b1, p == 0, DATA_W'($urandom), ev, ee, ew);
      checks++;
      if (o_valid !== ev || (ev && (window !== ew || o_eof !== ee))) begin
        errors++;
        $display("FAIL b2b_rand pos=%0d got v=%b %h e=%b want v=%b %h e=%b",
                 p, o_valid, window, o_eof, ev, ew, ee);
      end
      if (ev) nwin++;
    end
    checks++;
    if (nwin != NWIN) begin
      errors++;
      $display("FAIL b2b_rand_count got %0d want %0d", nwin, NWIN);
    end
    test_stream(0, 1'b1, "b2b_frame2");
  endtask

  task automatic test_midframe_sof;
    logic ev, ee;
    win_t ew;
    int early = 0;
    for (int p = 0; p < 3*IMG_W + 4; p++) begin
      drive(1'b1, p == 0, pat(p), ev, ee, ew);
      checks++;
      if (o_valid !== ev) begin
        errors++;
        $display("FAIL msof_pre_valid pos=%0d got %b want %b", p, o_valid, ev);
      end
    end
    for (int q = 0; q < NPIX; q++) begin
      drive(1'b1, q == 0, pat(q), ev, ee, ew);
      if (q < 2*IMG_W + 2 && o_valid === 1'b1) early++;
      if (q == 2*IMG_W + 2) begin
        checks++;
        if (early != 0 || o_valid !== 1'b1 || window[0][0] !== 8'h00 ||
            window[1][1] !== 8'h11 || window[2][2] !== 8'h22) begin
          errors++;
          $display("FAIL msof_resync got early=%0d valid=%b %h want 0 1 00..22", early, o_valid, window);
        end
      end
      checks++;
      if (o_valid !== ev || (ev && (window !== ew || o_eof !== ee))) begin
        errors++;
        $display("FAIL msof_post pos=%0d got v=%b %h e=%b want v=%b %h e=%b",
                 q, o_valid, window, o_eof, ev, ew, ee);
      end
    end
  endtask

  task automatic test_mid_reset;
    logic ev, ee;
    win_t ew;
    for (int p = 0; p < 4*IMG_W + 5; p++) begin
      drive(1'b1, p == 0, pat(p), ev, ee, ew);
    end
    checks++;
    if (o_valid !== 1'b1) begin
      errors++;
      $display("FAIL mrst_pre_valid got %b want 1", o_valid);
    end
    i_valid = 1'b1;
    i_pixel = pat(4*IMG_W + 5);
    rst_n   = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_eof !== 1'b0 || window !== '0) begin
      errors++;
      $display("FAIL mrst_clear got v=%b e=%b %h want 0 0 0", o_valid, o_eof, window);
    end
    m_pos = 0;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    rst_n   = 1'b1;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL mrst_held got %b want 0", o_valid);
    end
    test_stream(0, 1'b0, "post_reset");
  endtask

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    i_pixel = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_stream(0, 1'b1, "frame");
    test_line_boundary();
    test_stream(50, 1'b1, "gaps");
    test_back_to_back();
    test_midframe_sof();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
